// File: rtl/rf4x4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf4x4_pkg
// Description : Shared definitions for the rf4x4 pin-level register file
//               host master: FSM state encoding, target pin bit positions,
//               address/data widths and a helper that assembles a pin word.
// Revision    : 1.0 - initial release
// ============================================================================
package rf4x4_pkg;

  localparam int ADDR_W       = 2;
  localparam int DATA_W       = 4;
  localparam int PIN_W        = 8;

  // Bit positions on the target's io_in bus.
  localparam int PIN_CLK      = 0;
  localparam int PIN_WE       = 1;
  localparam int PIN_ADDR_LSB = 2;
  localparam int PIN_DATA_LSB = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_HIGH   = 3'd2,
    W_HOLD   = 3'd3,
    R_SETTLE = 3'd4,
    RESP     = 3'd5
  } state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Packs the individual pin fields into the 8-bit io_in word.
  function automatic logic [PIN_W-1:0] pin_word(input logic              pclk,
                                                input logic              we,
                                                input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] data);
    logic [PIN_W-1:0] w;
    w                          = '0;
    w[PIN_CLK]                 = pclk;
    w[PIN_WE]                  = we;
    w[PIN_ADDR_LSB +: ADDR_W]  = addr;
    w[PIN_DATA_LSB +: DATA_W]  = data;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf4x4_pin_master.sv
`default_nettype none
// ============================================================================
// Module      : rf4x4_pin_master
// Description : Host-side master for the 4-entry x 4-bit pin-level register
//               file. Converts single-cycle write/read requests into a timed
//               pin sequence (setup, strobe high, hold) on the target io_in
//               bus and samples the combinational read data from io_out.
//               Optional build macro RF4X4_PIN_MASTER_WRITE_VERIFY_EN adds a
//               read-back of every write and flags mismatches on rsp_err.
// Ports       : clk, reset         - system clock, synchronous active-high reset
//               req_valid/ready    - request handshake (ready only in IDLE)
//               req_write/addr/wdata - request fields, latched on accept
//               rsp_valid          - one-cycle completion pulse
//               rsp_rdata/rsp_err  - read data / verify mismatch
//               pin_out            - drives target io_in[7:0]
//               pin_in             - target io_out[3:0]
// Revision    : 1.0 - initial release
// ============================================================================
module rf4x4_pin_master
  import rf4x4_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int HIGH_CYC   = 2,
  parameter int HOLD_CYC   = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [PIN_W-1:0]  pin_out,
  input  logic [DATA_W-1:0] pin_in
);

  localparam int MAXC = max4(SETUP_CYC, HIGH_CYC, HOLD_CYC, SETTLE_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] c_setup_ld  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] c_high_ld   = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] c_hold_ld   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] c_settle_ld = CW'(SETTLE_CYC - 1);

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [ADDR_W-1:0]   addr_q, addr_nx;
  logic [DATA_W-1:0]   wdata_q, wdata_nx;
  logic [DATA_W-1:0]   rdata_nx;
  logic                err_nx;
  logic [PIN_W-1:0]    pin_nx;
  logic                ready_nx;
  logic                valid_nx;
  logic                accept;
`ifdef RF4X4_PIN_MASTER_WRITE_VERIFY_EN
  logic                write_q, write_nx;
`endif

  assign accept = req_valid && req_ready;

  // Next-state, counter and latched-request logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    rdata_nx = rsp_rdata;
    err_nx   = rsp_err;
`ifdef RF4X4_PIN_MASTER_WRITE_VERIFY_EN
    write_nx = write_q;
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          addr_nx  = req_addr;
          wdata_nx = req_wdata;
`ifdef RF4X4_PIN_MASTER_WRITE_VERIFY_EN
          write_nx = req_write;
`endif
          if (req_write) begin
            state_nx = W_SETUP;
            cnt_nx   = c_setup_ld;
          end else begin
            state_nx = R_SETTLE;
            cnt_nx   = c_settle_ld;
          end
        end
      end
      W_SETUP: begin
        if (cnt == '0) begin
          state_nx = W_HIGH;
          cnt_nx   = c_high_ld;
        end else begin
          cnt_nx   = cnt - 1'b1;
        end
      end
      W_HIGH: begin
        if (cnt == '0) begin
          state_nx = W_HOLD;
          cnt_nx   = c_hold_ld;
        end else begin
          cnt_nx   = cnt - 1'b1;
        end
      end
      W_HOLD: begin
        if (cnt == '0) begin
`ifdef RF4X4_PIN_MASTER_WRITE_VERIFY_EN
          state_nx = R_SETTLE;
          cnt_nx   = c_settle_ld;
`else
          // Plain writes report no data and never an error.
          state_nx = RESP;
          cnt_nx   = '0;
          rdata_nx = '0;
          err_nx   = 1'b0;
`endif
        end else begin
          cnt_nx   = cnt - 1'b1;
        end
      end
      R_SETTLE: begin
        if (cnt == '0) begin
          // Last settle cycle: the addressed entry has had time to propagate.
          state_nx = RESP;
          cnt_nx   = '0;
          rdata_nx = pin_in;
`ifdef RF4X4_PIN_MASTER_WRITE_VERIFY_EN
          err_nx   = write_q && (pin_in != wdata_q);
`else
          err_nx   = 1'b0;
`endif
        end else begin
          cnt_nx   = cnt - 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the next state and take
  // effect in the same cycle the FSM enters that state.
  always_comb begin
    pin_nx   = '0;
    ready_nx = (state_nx == IDLE);
    valid_nx = (state_nx == RESP);
    case (state_nx)
      W_SETUP:  pin_nx = pin_word(1'b0, 1'b1, addr_nx, wdata_nx);
      W_HIGH:   pin_nx = pin_word(1'b1, 1'b1, addr_nx, wdata_nx);
      W_HOLD:   pin_nx = pin_word(1'b0, 1'b1, addr_nx, wdata_nx);
      R_SETTLE: pin_nx = pin_word(1'b0, 1'b0, addr_nx, '0);
      default:  pin_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pin_out   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef RF4X4_PIN_MASTER_WRITE_VERIFY_EN
      write_q   <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      addr_q    <= addr_nx;
      wdata_q   <= wdata_nx;
      pin_out   <= pin_nx;
      req_ready <= ready_nx;
      rsp_valid <= valid_nx;
      rsp_rdata <= rdata_nx;
      rsp_err   <= err_nx;
`ifdef RF4X4_PIN_MASTER_WRITE_VERIFY_EN
      write_q   <= write_nx;
`endif
    end
  end

endmodule
`default_nettype wire
